sdram_port_arbiter: RTL

Shares the single SDRAM controller port between three requesters: the ioctl downloader (ROM/cartridge/tape image writes), the Z80 CPU memory bus, and tape playback reads. It applies fixed priority with anti-starvation for the tape, and prefers CPU refresh windows for tape reads. It serialises one transaction at a time with a request/acknowledge handshake per requester. It sits between the top-level memory muxing and the sdram controller, replacing the combinational address/rd/we selection.

---
 rtl/sdram_port_arbiter.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
// Shares the single SDRAM controller port between the ioctl downloader, the
// Z80 CPU bus and tape playback. One transaction is in flight at a time:
// IDLE (arbitrate) -> ISSUE (strobe) -> WAIT (mem_ready or timeout) -> DONE.
// Priority: downloader, then a starved or refresh-window tape request, then
// CPU, then tape. Acks are registered and appear the cycle after DONE.

module sdram_port_arbiter #(
    parameter int ADDR_W        = 23,
    parameter int TAPE_MAX_WAIT = 64,
    parameter int TIMEOUT       = 255
) (
    input  logic              clk_sys,
    input  logic              reset,

    input  logic              dl_req,
    input  logic [ADDR_W-1:0] dl_addr,
    input  logic [7:0]        dl_data,
    output logic              dl_ack,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_ack,

    input  logic              tape_req,
    input  logic [ADDR_W-1:0] tape_addr,
    output logic [7:0]        tape_rdata,
    output logic              tape_ack,

    input  logic              rfsh_window,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_din,
    output logic              mem_rd,
    output logic              mem_we,
    input  logic [15:0]       mem_dout,
    input  logic              mem_ready,

    output logic              busy,
    output logic              timeout_err
);

    // Tape wait counter saturates at TAPE_MAX_WAIT, so it needs to hold that value.
    localparam int TW_W = $clog2(TAPE_MAX_WAIT + 1);
    // WAIT counter runs 0 .. TIMEOUT-1; the last value aborts the transaction.
    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [TW_W-1:0] TAPE_MAX_V = TW_W'(TAPE_MAX_WAIT);
    localparam logic [TO_W-1:0] TO_LAST_V  = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        OWN_DL,
        OWN_CPU,
        OWN_TAPE
    } owner_t;

    state_t              state_q;
    owner_t              owner_q;
    logic                is_write_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [7:0]          byte_q;
    logic                mem_rd_q;
    logic                mem_we_q;
    logic                dl_ack_q;
    logic                cpu_ack_q;
    logic                tape_ack_q;
    logic [7:0]          cpu_rdata_q;
    logic [7:0]          tape_rdata_q;
    logic                busy_q;
    logic                timeout_err_q;
    logic [TO_W-1:0]     tmo_q;
    logic [TW_W-1:0]     tape_wait_q;
    logic [TW_W-1:0]     tape_wait_d;

    logic                grant_valid_d;
    owner_t              grant_owner_d;
    logic                tape_promote;
    logic                tape_granted;
    logic                wait_finish;
    logic [7:0]          wait_byte;
    logic                dout_hi_unused;

    // Only the low byte of the controller word carries data.
    assign dout_hi_unused = ^mem_dout[15:8];

    // A tape request jumps ahead of the CPU when it has waited long enough or
    // the CPU is in a refresh cycle and therefore cannot be using the bus.
    assign tape_promote = tape_req && (rfsh_window || (tape_wait_q >= TAPE_MAX_V));

    // Fixed-priority arbitration, evaluated every IDLE cycle.
    always_comb begin
        grant_valid_d = 1'b0;
        grant_owner_d = OWN_DL;
        if (dl_req) begin
            grant_valid_d = 1'b1;
            grant_owner_d = OWN_DL;
        end else if (tape_promote) begin
            grant_valid_d = 1'b1;
            grant_owner_d = OWN_TAPE;
        end else if (cpu_req) begin
            grant_valid_d = 1'b1;
            grant_owner_d = OWN_CPU;
        end else if (tape_req) begin
            grant_valid_d = 1'b1;
            grant_owner_d = OWN_TAPE;
        end
    end

    assign tape_granted = (state_q == ST_IDLE) && grant_valid_d && (grant_owner_d == OWN_TAPE);

    // Tape starvation counter: counts every cycle a tape request is left pending.
    always_comb begin
        tape_wait_d = tape_wait_q;
        if (!tape_req || tape_granted) begin
            tape_wait_d = '0;
        end else if (tape_wait_q < TAPE_MAX_V) begin
            tape_wait_d = tape_wait_q + TW_W'(1);
        end
    end

    // Tape wait counter register.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            tape_wait_q <= '0;
        end else begin
            tape_wait_q <= tape_wait_d;
        end
    end

    // WAIT ends on controller completion or when the timeout budget runs out;
    // an aborted read returns 8'hFF.
    assign wait_finish = mem_ready || (tmo_q == TO_LAST_V);
    assign wait_byte   = mem_ready ? mem_dout[7:0] : 8'hFF;

    // Transaction FSM with registered strobes, acks, read data and status.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            owner_q       <= OWN_DL;
            is_write_q    <= 1'b0;
            addr_q        <= '0;
            byte_q        <= '0;
            mem_rd_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            dl_ack_q      <= 1'b0;
            cpu_ack_q     <= 1'b0;
            tape_ack_q    <= 1'b0;
            cpu_rdata_q   <= '0;
            tape_rdata_q  <= '0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            tmo_q         <= '0;
        end else begin
            mem_rd_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            dl_ack_q   <= 1'b0;
            cpu_ack_q  <= 1'b0;
            tape_ack_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (grant_valid_d) begin
                        owner_q <= grant_owner_d;
                        state_q <= ST_ISSUE;
                        busy_q  <= 1'b1;
                        // Strobe is registered here so it is high exactly during ISSUE.
                        case (grant_owner_d)
                            OWN_DL: begin
                                addr_q     <= dl_addr;
                                byte_q     <= dl_data;
                                is_write_q <= 1'b1;
                                mem_we_q   <= 1'b1;
                            end
                            OWN_CPU: begin
                                addr_q     <= cpu_addr;
                                byte_q     <= cpu_wdata;
                                is_write_q <= cpu_we;
                                mem_we_q   <= cpu_we;
                                mem_rd_q   <= !cpu_we;
                            end
                            default: begin
                                addr_q     <= tape_addr;
                                byte_q     <= 8'h00;
                                is_write_q <= 1'b0;
                                mem_rd_q   <= 1'b1;
                            end
                        endcase
                    end
                end

                ST_ISSUE: begin
                    state_q <= ST_WAIT;
                    tmo_q   <= '0;
                end

                ST_WAIT: begin
                    if (wait_finish) begin
                        if (!mem_ready) begin
                            timeout_err_q <= 1'b1;
                        end
                        if (!is_write_q) begin
                            if (owner_q == OWN_CPU) begin
                                cpu_rdata_q <= wait_byte;
                            end else if (owner_q == OWN_TAPE) begin
                                tape_rdata_q <= wait_byte;
                            end
                        end
                        state_q <= ST_DONE;
                    end else begin
                        tmo_q <= tmo_q + TO_W'(1);
                    end
                end

                ST_DONE: begin
                    dl_ack_q   <= (owner_q == OWN_DL);
                    cpu_ack_q  <= (owner_q == OWN_CPU);
                    tape_ack_q <= (owner_q == OWN_TAPE);
                    state_q    <= ST_IDLE;
                    busy_q     <= 1'b0;
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr    = addr_q;
    assign mem_din     = {8'h00, byte_q};
    assign mem_rd      = mem_rd_q;
    assign mem_we      = mem_we_q;
    assign dl_ack      = dl_ack_q;
    assign cpu_ack     = cpu_ack_q;
    assign tape_ack    = tape_ack_q;
    assign cpu_rdata   = cpu_rdata_q;
    assign tape_rdata  = tape_rdata_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

endmodule
